// File: rtl/c2f_chunk_drain_pkg.sv
// Shared types and constants for the CPU->FPGA chunk path (same types the transceiver uses).
package c2f_chunk_drain_pkg;

  localparam int unsigned C2F_CHUNKSIZE_NBITS = 4;
  localparam int unsigned C2F_NUMCHUNKS_NBITS = 2;
  localparam int unsigned C2F_NUMCHUNKS       = 1 << C2F_NUMCHUNKS_NBITS;
  localparam int unsigned C2F_ADDR_W          = C2F_NUMCHUNKS_NBITS + C2F_CHUNKSIZE_NBITS;

  typedef logic [C2F_NUMCHUNKS_NBITS-1:0] C2FChunkIndex;
  typedef logic [C2F_CHUNKSIZE_NBITS-1:0] C2FChunkOffset;
  typedef logic [7:0]                     ByteMask64;
  typedef logic [63:0]                    uint64;

  localparam C2FChunkOffset C2F_LAST_OFFSET = '1;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_FETCH,
    DR_STREAM
  } drain_state_e;

  // One drained beat as held in the output skid entry.
  typedef struct packed {
    logic  last;
    uint64 data;
  } dr_beat_t;

  // Byte-lane merge: lanes with mask set take new data, others keep old.
  function automatic uint64 mask_merge(uint64 old_val, uint64 new_val, ByteMask64 mask);
    uint64 r;
    r = old_val;
    for (int b = 0; b < 8; b++) begin
      if (mask[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/c2f_chunk_drain_ram.sv
// c2f_chunk_ram: 64 x 64-bit byte-masked simple dual-port store, 1-cycle registered read.
// BLOCK_RAM=1 uses per-lane arrays (byte-enable RAM shape), 0 uses a flop array; same timing.
module c2f_chunk_ram
  import c2f_chunk_drain_pkg::*;
#(
  parameter int unsigned BLOCK_RAM = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [C2F_ADDR_W-1:0] wr_addr,
  input  ByteMask64             wr_mask,
  input  uint64                 wr_data,
  input  logic                  rd_en,
  input  logic [C2F_ADDR_W-1:0] rd_addr,
  output uint64                 rd_data
);

  localparam int unsigned DEPTH = 1 << C2F_ADDR_W;

  uint64 mem_rd;
  uint64 rd_data_q;
  uint64 rd_data_d;

  if (BLOCK_RAM != 0) begin : g_bram
    logic [7:0] lane_mem [8][DEPTH];

    // Per-lane write with byte enable.
    always_ff @(posedge clk) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_en && wr_mask[b]) lane_mem[b][wr_addr] <= wr_data[8*b +: 8];
      end
    end

    // Gather the lanes at the read address.
    always_comb begin
      mem_rd = '0;
      for (int b = 0; b < 8; b++) begin
        mem_rd[8*b +: 8] = lane_mem[b][rd_addr];
      end
    end
  end else begin : g_regs
    uint64 mem_q [DEPTH];

    // Read-modify-write of the addressed qword under the byte mask.
    always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= mask_merge(mem_q[wr_addr], wr_data, wr_mask);
    end

    // Flop-array read mux.
    always_comb begin
      mem_rd = mem_q[rd_addr];
    end
  end

  // Read register only loads on a read so the value holds during output stalls.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_rd;
  end

  // Read data register; contents of the array itself are never reset.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/c2f_chunk_drain.sv
// c2f_chunk_drain: stores CPU->FPGA chunks and drains each committed chunk as a
// 16-qword valid/ready stream, releasing it to the transceiver with c2fDTAck_out.
// Optional consistency checker enabled by defining C2F_DRAIN_CHECK_EN.
module c2f_chunk_drain
  import c2f_chunk_drain_pkg::*;
#(
  parameter int unsigned BLOCK_RAM = 1
) (
  input  logic         pcieClk_in,
  input  logic         reset_in,
  input  logic         c2fWriteEnable_in,
  input  ByteMask64    c2fByteMask_in,
  input  C2FChunkIndex c2fWrPtr_in,
  input  C2FChunkOffset c2fChunkOffset_in,
  input  uint64        c2fData_in,
  output logic         c2fDTAck_out,
  input  C2FChunkIndex c2fRdPtr_in,
  output uint64        drData_out,
  output logic         drValid_out,
  input  logic         drReady_in,
  output logic         drLast_out,
  output logic         drOverflow_out
);

  drain_state_e             state_q, state_d;
  C2FChunkIndex             rd_ptr_q, rd_ptr_d;
  C2FChunkOffset            rd_off_q, rd_off_d;
  logic [C2F_NUMCHUNKS-1:0] full_q, full_d;
  logic                     ram_v_q, ram_v_d;
  logic                     ram_last_q, ram_last_d;
  dr_beat_t                 skid_q, skid_d;
  logic                     skid_v_q, skid_v_d;
  logic                     ack_q, ack_d;
  logic                     ovf_q, ovf_d;

  uint64 ram_rd_data;
  logic  rd_en;
  logic  xfer, pop_skid, pop_ram, ram_live, can_issue, last_xfer, commit;

  c2f_chunk_ram #(.BLOCK_RAM(BLOCK_RAM)) u_ram (
    .clk     (pcieClk_in),
    .rst     (reset_in),
    .wr_en   (c2fWriteEnable_in),
    .wr_addr ({c2fWrPtr_in, c2fChunkOffset_in}),
    .wr_mask (c2fByteMask_in),
    .wr_data (c2fData_in),
    .rd_en   (rd_en),
    .rd_addr ({rd_ptr_q, rd_off_q}),
    .rd_data (ram_rd_data)
  );

  // Output head: the skid entry is older than the RAM read register when both hold data.
  assign drValid_out    = skid_v_q | ram_v_q;
  assign drData_out     = skid_v_q ? skid_q.data : ram_rd_data;
  assign drLast_out     = skid_v_q ? skid_q.last : ram_last_q;
  assign c2fDTAck_out   = ack_q;
  assign drOverflow_out = ovf_q;

  // Handshake decode and read-issue credit (two in-flight slots: RAM register + skid).
  always_comb begin
    xfer      = drValid_out & drReady_in;
    pop_skid  = xfer & skid_v_q;
    pop_ram   = xfer & ~skid_v_q;
    ram_live  = ram_v_q & ~pop_ram;
    can_issue = ~(skid_v_q & ram_live & ~pop_skid);
    last_xfer = xfer & drLast_out;
    commit    = c2fWriteEnable_in && (c2fChunkOffset_in == C2F_LAST_OFFSET);
  end

  // FSM state register.
  always_ff @(posedge pcieClk_in) begin
    if (reset_in) state_q <= DR_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DR_IDLE:   if (full_q[rd_ptr_q] && can_issue) state_d = DR_FETCH;
      DR_FETCH:  if (can_issue && rd_off_q == C2F_LAST_OFFSET) state_d = DR_STREAM;
      DR_STREAM: if (last_xfer) state_d = DR_IDLE;
      default:   state_d = DR_IDLE;
    endcase
  end

  // FSM outputs: offset 0 is issued on the IDLE->FETCH cycle to meet the 2-cycle latency.
  always_comb begin
    rd_en = 1'b0;
    unique case (state_q)
      DR_IDLE:  rd_en = full_q[rd_ptr_q] && can_issue;
      DR_FETCH: rd_en = can_issue;
      default:  rd_en = 1'b0;
    endcase
  end

  // Datapath next state: read offset, skid buffer, chunk flags, pointer and ack.
  always_comb begin
    rd_off_d   = rd_en ? C2FChunkOffset'(rd_off_q + 1'b1) : rd_off_q;
    ram_v_d    = rd_en | ram_live;
    ram_last_d = rd_en ? (rd_off_q == C2F_LAST_OFFSET) : ram_last_q;

    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (pop_skid) skid_v_d = 1'b0;
    if (rd_en && ram_live) begin
      skid_d   = '{last: ram_last_q, data: ram_rd_data};
      skid_v_d = 1'b1;
    end

    full_d = full_q;
    if (last_xfer) full_d[rd_ptr_q] = 1'b0;
    if (commit)    full_d[c2fWrPtr_in] = 1'b1;

    rd_ptr_d = last_xfer ? C2FChunkIndex'(rd_ptr_q + 1'b1) : rd_ptr_q;
    ack_d    = last_xfer;
  end

`ifdef C2F_DRAIN_CHECK_EN
  logic wr_clash, ptr_skew;
  // Sticky overflow: overwrite of undrained data, or release pointer out of step while idle.
  // The ack cycle is excluded because the transceiver's pointer advances one edge later.
  always_comb begin
    wr_clash = c2fWriteEnable_in &&
               ((commit && full_q[c2fWrPtr_in]) ||
                (state_q != DR_IDLE && c2fWrPtr_in == rd_ptr_q));
    ptr_skew = (state_q == DR_IDLE) && !ack_q && (c2fRdPtr_in != rd_ptr_q);
    ovf_d    = ovf_q | wr_clash | ptr_skew;
  end
`else
  logic unused_rd_ptr;
  assign unused_rd_ptr = ^c2fRdPtr_in;
  // Checker disabled: overflow flag tied low.
  always_comb begin
    ovf_d = 1'b0;
  end
`endif

  // Datapath registers.
  always_ff @(posedge pcieClk_in) begin
    if (reset_in) begin
      rd_off_q   <= '0;
      ram_v_q    <= 1'b0;
      ram_last_q <= 1'b0;
      skid_q     <= '0;
      skid_v_q   <= 1'b0;
      full_q     <= '0;
      rd_ptr_q   <= '0;
      ack_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_off_q   <= rd_off_d;
      ram_v_q    <= ram_v_d;
      ram_last_q <= ram_last_d;
      skid_q     <= skid_d;
      skid_v_q   <= skid_v_d;
      full_q     <= full_d;
      rd_ptr_q   <= rd_ptr_d;
      ack_q      <= ack_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_c2f_chunk_drain.sv
// Directed bench for c2f_chunk_drain: drain order/data, latency, stalls, masks, overflow, reset.
module tb_c2f_chunk_drain;
  import c2f_chunk_drain_pkg::*;

  logic          clk = 1'b0;
  logic          reset_in = 1'b1;
  logic          c2fWriteEnable_in = 1'b0;
  ByteMask64     c2fByteMask_in = '0;
  C2FChunkIndex  c2fWrPtr_in = '0;
  C2FChunkOffset c2fChunkOffset_in = '0;
  uint64         c2fData_in = '0;
  logic          c2fDTAck_out;
  C2FChunkIndex  c2fRdPtr_in;
  uint64         drData_out;
  logic          drValid_out;
  logic          drReady_in = 1'b0;
  logic          drLast_out;
  logic          drOverflow_out;

  always #4 clk = ~clk;

  c2f_chunk_drain #(.BLOCK_RAM(1)) dut (
    .pcieClk_in        (clk),
    .reset_in          (reset_in),
    .c2fWriteEnable_in (c2fWriteEnable_in),
    .c2fByteMask_in    (c2fByteMask_in),
    .c2fWrPtr_in       (c2fWrPtr_in),
    .c2fChunkOffset_in (c2fChunkOffset_in),
    .c2fData_in        (c2fData_in),
    .c2fDTAck_out      (c2fDTAck_out),
    .c2fRdPtr_in       (c2fRdPtr_in),
    .drData_out        (drData_out),
    .drValid_out       (drValid_out),
    .drReady_in        (drReady_in),
    .drLast_out        (drLast_out),
    .drOverflow_out    (drOverflow_out)
  );

`ifdef C2F_DRAIN_CHECK_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned commit_cyc = 0;
  int unsigned first_xfer_cyc = 0;
  int unsigned last_xfer_cyc = 0;
  bit          seen_first = 1'b0;
  int          xfer_cnt = 0;
  int          ack_cnt = 0;
  int          rdy_mode = 1;
  logic [64:0] exp_q[$];
  logic [64:0] exp_beat;
  logic [64:0] prev_beat = '0;
  logic        prev_stall = 1'b0;
  logic        prev_ack = 1'b0;
  C2FChunkIndex rd_ptr_m = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transceiver release pointer: advances on each ack.
  always @(posedge clk) begin
    if (reset_in)          rd_ptr_m <= '0;
    else if (c2fDTAck_out) rd_ptr_m <= rd_ptr_m + 2'd1;
  end
  assign c2fRdPtr_in = rd_ptr_m;

  // Ready pattern: 0 low, 1 high, otherwise toggle every cycle.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       drReady_in = 1'b0;
      1:       drReady_in = 1'b1;
      default: drReady_in = ~drReady_in;
    endcase
  end

  // Output monitor: scoreboard transfers, stall stability, ack pulse width.
  always @(negedge clk) begin
    if (reset_in) begin
      prev_stall = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_data", drData_out, prev_beat[63:0]);
        check("stall_ctl", 64'({drValid_out, drLast_out}), 64'({1'b1, prev_beat[64]}));
      end
      if (drValid_out && drReady_in) begin
        if (!seen_first) begin
          first_xfer_cyc = cyc;
          seen_first     = 1'b1;
        end
        last_xfer_cyc = cyc;
        xfer_cnt++;
        check("xfer_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp_beat = exp_q.pop_front();
          check("dr_data", drData_out, exp_beat[63:0]);
          check("dr_last", 64'(drLast_out), 64'(exp_beat[64]));
        end
      end
      if (c2fDTAck_out) begin
        ack_cnt++;
        check("ack_width", 64'(prev_ack), 64'd0);
      end
      prev_ack   = c2fDTAck_out;
      prev_stall = drValid_out && !drReady_in;
      prev_beat  = {drLast_out, drData_out};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input C2FChunkIndex c, input C2FChunkOffset o, input uint64 d, input ByteMask64 m);
    c2fWriteEnable_in = 1'b1;
    c2fWrPtr_in       = c;
    c2fChunkOffset_in = o;
    c2fData_in        = d;
    c2fByteMask_in    = m;
    tick();
    c2fWriteEnable_in = 1'b0;
  endtask

  task automatic write_chunk(input C2FChunkIndex c, input uint64 base);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) commit_cyc = cyc;
      exp_q.push_back({i == 15, base + 64'(i)});
      wr(c, C2FChunkOffset'(i), base + 64'(i), 8'hFF);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) tick();
    check("drain_done", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    rdy_mode = 1;
    repeat (2) tick();
    reset_in = 1'b0;

    // Reset values
    check("rst_valid", 64'(drValid_out), 64'd0);
    check("rst_last", 64'(drLast_out), 64'd0);
    check("rst_data", drData_out, 64'd0);
    check("rst_ack", 64'(c2fDTAck_out), 64'd0);
    check("rst_ovf", 64'(drOverflow_out), 64'd0);

    // Single chunk 0, ready high: latency 2, 16 consecutive beats, one ack
    ack_cnt = 0; xfer_cnt = 0; seen_first = 1'b0;
    write_chunk(2'd0, 64'h1000);
    wait_drain();
    check("t1_latency", 64'(first_xfer_cyc), 64'(commit_cyc + 2));
    check("t1_span", 64'(last_xfer_cyc - first_xfer_cyc), 64'd15);
    check("t1_count", 64'(xfer_cnt), 64'd16);
    check("t1_ack", 64'(ack_cnt), 64'd1);

    // Byte-masked rewrite of offset 3 in chunk 1 (release pointer is now 1)
    ack_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        wr(2'd1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr(2'd1, 4'd3, 64'h0, 8'h0F);
        exp_q.push_back({1'b0, 64'hFFFF_FFFF_0000_0000});
      end else begin
        exp_q.push_back({i == 15, 64'h2000 + 64'(i)});
        wr(2'd1, C2FChunkOffset'(i), 64'h2000 + 64'(i), 8'hFF);
      end
    end
    wait_drain();
    check("t3_ack", 64'(ack_cnt), 64'd1);

    // Four back-to-back chunks with ready toggling, then chunk 0 again after the wrap
    do_reset();
    rdy_mode = 2; ack_cnt = 0;
    for (int c = 0; c < 4; c++) write_chunk(C2FChunkIndex'(c), 64'h3000 + 64'(16 * c));
    wait_drain();
    check("t2_ack", 64'(ack_cnt), 64'd4);
    check("t2_ovf", 64'(drOverflow_out), 64'd0);
    write_chunk(2'd0, 64'h4000);
    wait_drain();
    check("t2_wrap_ack", 64'(ack_cnt), 64'd5);

    // Five commits with no draining: overflow on the fifth, sticky until reset
    rdy_mode = 0;
    do_reset();
    for (int c = 0; c < 4; c++) write_chunk(C2FChunkIndex'(c), 64'h7000 + 64'(16 * c));
    tick();
    check("t4_ovf_pre", 64'(drOverflow_out), 64'd0);
    write_chunk(2'd0, 64'h7100);
    repeat (2) tick();
    check("t4_ovf_set", 64'(drOverflow_out), 64'(EXP_OVF));
    repeat (5) tick();
    check("t4_ovf_hold", 64'(drOverflow_out), 64'(EXP_OVF));
    do_reset();
    check("t4_ovf_clr", 64'(drOverflow_out), 64'd0);

    // Reset after qword 7 transfers: chunk abandoned without ack, fresh chunk drains
    rdy_mode = 1;
    tick();
    do_reset();
    ack_cnt = 0; xfer_cnt = 0;
    write_chunk(2'd0, 64'h5000);
    for (int k = 0; k < 100 && xfer_cnt < 8; k++) tick();
    check("t5_reach_q7", 64'(xfer_cnt >= 8), 64'd1);
    do_reset();
    check("t5_valid_low", 64'(drValid_out), 64'd0);
    check("t5_ack_low", 64'(c2fDTAck_out), 64'd0);
    repeat (4) tick();
    check("t5_no_ack", 64'(ack_cnt), 64'd0);
    write_chunk(2'd0, 64'h6000);
    wait_drain();
    check("t5_fresh_ack", 64'(ack_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
